// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator.
package tick_gen_pkg;

  localparam int TG_MAX_NCH = 16;
  localparam int TG_MIN_DIV = 2;

  // Effective divisor: 0 and 1 both mean "tick every enabled cycle".
  function automatic logic [31:0] tg_eff_div(input logic [31:0] div);
    logic [31:0] d_s;
    if (div < 32'(TG_MIN_DIV)) begin
      d_s = 32'd1;
    end else begin
      d_s = div;
    end
    return d_s;
  endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Control/status bundle of the tick generator: enables, divisor loading, ticks.
interface tick_gen_multi_if #(
  parameter int NCH = 4,
  parameter int W   = 16
);
  logic [NCH-1:0] en;
  logic           sync_clr;
  logic [NCH-1:0] div_load;
  logic [W-1:0]   div_value;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  modport master (
    output en, sync_clr, div_load, div_value,
    input  tick, pend
  );

  modport slave (
    input  en, sync_clr, div_load, div_value,
    output tick, pend
  );
endinterface

// File: rtl/tick_gen_chan.sv
// One tick channel: period counter, active/pending divisor and registered tick.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int W       = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  input  logic         sync_clr,
  input  logic         div_load,
  input  logic [W-1:0] div_value,
  output logic         tick,
  output logic         pend
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] DEF = W'(DEF_DIV);

  logic [W-1:0] cnt_r, cnt_s;
  logic [W-1:0] div_act_r, div_act_s;
  logic [W-1:0] div_pend_r, div_pend_s;
  logic         pend_r, pend_s;
  logic         tick_r, tick_s;
  logic [W-1:0] deff_s;
  logic         wrap_s;

  // Period end detection; >= also covers an out-of-range count as a wrap.
  always_comb begin
    deff_s = W'(tg_eff_div(32'(div_act_r)));
    wrap_s = (cnt_r >= (deff_s - ONE));
  end

  // Next-state: clear / count / freeze, divisor hand-over, then capture a new load.
  always_comb begin
    cnt_s      = cnt_r;
    div_act_s  = div_act_r;
    div_pend_s = div_pend_r;
    pend_s     = pend_r;
    tick_s     = 1'b0;
    if (sync_clr) begin
      cnt_s = '0;
      if (pend_r) begin
        div_act_s = div_pend_r;
        pend_s    = 1'b0;
      end else begin
        div_act_s = div_act_r;
      end
    end else if (en) begin
      if (wrap_s) begin
        cnt_s  = '0;
        tick_s = 1'b1;
        // The completing period already used the old divisor.
        if (pend_r) begin
          div_act_s = div_pend_r;
          pend_s    = 1'b0;
        end else begin
          div_act_s = div_act_r;
        end
      end else begin
        cnt_s = cnt_r + ONE;
      end
    end else begin
      // A frozen channel has no phase to protect, so update at once.
      if (pend_r) begin
        div_act_s = div_pend_r;
        pend_s    = 1'b0;
      end else begin
        div_act_s = div_act_r;
      end
    end
    // A load on the same edge as a hand-over stays pending for the next one.
    if (div_load) begin
      div_pend_s = div_value;
      pend_s     = 1'b1;
    end else begin
      div_pend_s = div_pend_s;
    end
  end

  // Channel state registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_r      <= '0;
      div_act_r  <= DEF;
      div_pend_r <= DEF;
      pend_r     <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      div_act_r  <= div_act_s;
      div_pend_r <= div_pend_s;
      pend_r     <= pend_s;
      tick_r     <= tick_s;
    end
  end

  assign tick = tick_r;
  assign pend = pend_r;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: NCH independent divider channels.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst_,
  tick_gen_multi_if.slave bus
);

  logic [NCH-1:0] tick_s;
  logic [NCH-1:0] pend_s;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      tick_gen_chan #(
        .W       (W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clk       (clk),
        .rst_      (rst_),
        .en        (bus.en[i]),
        .sync_clr  (bus.sync_clr),
        .div_load  (bus.div_load[i]),
        .div_value (bus.div_value),
        .tick      (tick_s[i]),
        .pend      (pend_s[i])
      );
    end
  endgenerate

  assign bus.tick = tick_s;
  assign bus.pend = pend_s;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi with a period-based reference model.
module tb_tick_gen_multi;
  import tick_gen_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 8;
  localparam int DEF = 5;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  tick_gen_multi_if #(.NCH(NCH), .W(W)) bus ();

  tick_gen_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: position inside the current period, active and queued divisor.
  int pos[NCH];
  int act[NCH];
  int pv[NCH];
  bit hp[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      pos[i] = 0; act[i] = DEF; pv[i] = DEF; hp[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] e, input logic sc,
                            input logic [NCH-1:0] ld, input logic [W-1:0] v,
                            output exp_t x);
    int period;
    bit switch_now;
    x = '0;
    for (int i = 0; i < NCH; i++) begin
      period = int'(tg_eff_div(32'(act[i])));
      switch_now = 1'b0;
      if (sc) begin
        pos[i] = 0;
        switch_now = 1'b1;
      end else if (e[i]) begin
        if (pos[i] + 1 >= period) begin
          x.tick[i] = 1'b1;
          pos[i] = 0;
          switch_now = 1'b1;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end else begin
        switch_now = 1'b1;
      end
      if (switch_now && hp[i]) begin
        act[i] = pv[i];
        hp[i] = 1'b0;
      end
      if (ld[i]) begin
        pv[i] = int'(v);
        hp[i] = 1'b1;
      end
      x.pend[i] = hp[i];
    end
  endtask

  // One stimulus cycle: drive on the falling edge, queue the post-edge expectation.
  task automatic cycle(input logic [NCH-1:0] e, input logic sc,
                       input logic [NCH-1:0] ld, input logic [W-1:0] v);
    exp_t x;
    @(negedge clk);
    bus.en = e; bus.sync_clr = sc; bus.div_load = ld; bus.div_value = v;
    model_step(e, sc, ld, v, x);
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input logic [NCH-1:0] e);
    for (int k = 0; k < n; k++) cycle(e, 1'b0, 2'b00, 8'd0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // Monitor: every rising edge after reset the outputs are compared to the queue head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (bus.tick !== x.tick || bus.pend !== x.pend) begin
          errors++;
          $display("FAIL scoreboard t=%0t tick=%b pend=%b want tick=%b pend=%b",
                   $time, bus.tick, bus.pend, x.tick, x.pend);
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] e, ld;
    logic sc;
    bus.en = '0; bus.sync_clr = 1'b0; bus.div_load = '0; bus.div_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_tick", 32'(bus.tick), 32'd0);
    check("reset_pend", 32'(bus.pend), 32'd0);
    rst_ = 1'b1;

    // Default period: ticks after edges 5, 10, 15 on both channels.
    for (int k = 1; k <= 16; k++) begin
      cycle(2'b11, 1'b0, 2'b00, 8'd0);
      @(posedge clk); #2;
      check("default_period", 32'(bus.tick), (k % 5 == 0) ? 32'd3 : 32'd0);
    end

    // Reload at boundary (ch0 at cnt=1, new divisor 3).
    cycle(2'b11, 1'b0, 2'b01, 8'd3);
    run(20, 2'b11);
    // Enable freeze on ch1 with divisor 4, and a load applied while frozen.
    cycle(2'b11, 1'b0, 2'b10, 8'd4);
    run(8, 2'b11);
    run(2, 2'b11);
    run(3, 2'b01);
    cycle(2'b01, 1'b0, 2'b10, 8'd6);
    run(6, 2'b01);
    run(14, 2'b11);
    // Degenerate divisors 0, 1 and 2 on ch0.
    cycle(2'b11, 1'b0, 2'b01, 8'd0);
    run(8, 2'b11);
    cycle(2'b11, 1'b0, 2'b01, 8'd1);
    run(6, 2'b11);
    cycle(2'b11, 1'b0, 2'b01, 8'd2);
    run(8, 2'b11);
    // Sync clear: both 7, skewed phases, pending 9 on ch1 applied at the clear.
    cycle(2'b11, 1'b0, 2'b11, 8'd7);
    run(10, 2'b11);
    run(3, 2'b01);
    run(5, 2'b11);
    cycle(2'b11, 1'b0, 2'b10, 8'd9);
    cycle(2'b11, 1'b1, 2'b00, 8'd0);
    run(20, 2'b11);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      e  = 2'($urandom_range(0, 7) != 0) | (2'($urandom_range(0, 7) != 0) << 1);
      sc = ($urandom_range(0, 63) == 0);
      ld = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
      cycle(e, sc, ld, 8'($urandom_range(0, 12)));
    end

    // Arrange tick=1 and pend=1 on both channels, then reset between edges.
    cycle(2'b11, 1'b1, 2'b11, 8'd1);
    cycle(2'b00, 1'b0, 2'b00, 8'd0);
    cycle(2'b11, 1'b0, 2'b11, 8'd2);
    @(posedge clk); #3;
    check("pre_reset_tick", 32'(bus.tick), 32'd3);
    rst_ = 1'b0;
    #1;
    check("async_reset_tick", 32'(bus.tick), 32'd0);
    check("async_reset_pend", 32'(bus.pend), 32'd0);
    model_reset();
    @(negedge clk);
    bus.en = '0; bus.div_load = '0; bus.sync_clr = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    // Divisor back to the default after reset.
    for (int k = 1; k <= 11; k++) begin
      cycle(2'b11, 1'b0, 2'b00, 8'd0);
      @(posedge clk); #2;
      check("post_reset_period", 32'(bus.tick), (k % 5 == 0) ? 32'd3 : 32'd0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
